hept_stage_sequencer: RTL and testbench
=======================================

Name: hept_stage_sequencer

Overview:
- Sequences the HEPT kernel's ap_ctrl_hs sub-blocks in fixed order (transpose_qk -> pairwise_dist_sq_rbf -> mask_and_normalize), one at a time, from a single top-level ap_ctrl_hs handshake.
- Records per-stage cycle counts, which feed the module_status CSV performance flow.
- Sits between the top kernel control and the stage instances.

Parameters:
- N_STAGES, 3, number of sequenced stages; stage 0 runs first.
- CNT_W, 16, width of each per-stage cycle counter; counter saturates.
- WDOG_CYCLES, 65535, per-stage timeout in cycles; used only when the optional feature is compiled in.

Ports:
- clock  in  1  kernel clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  top-level start; held high by the host until ap_ready.
- ap_done  out  1  one-cycle pulse when the sequence completes or aborts.
- ap_ready  out  1  equals ap_done; the host drops ap_start on this cycle.
- ap_idle  out  1  high in IDLE.
- stg_start  out  N_STAGES  per-stage ap_start; at most one bit high.
- stg_ready  in  N_STAGES  per-stage ap_ready.
- stg_done  in  N_STAGES  per-stage ap_done pulse.
- cur_stage  out  $clog2(N_STAGES)  index of the active stage; 0 in IDLE.
- stg_cycles  out  N_STAGES*CNT_W  flattened counters; stage i occupies bits [i*CNT_W +: CNT_W].
- err  out  1  abort flag; present only with HEPT_SEQ_WDOG_EN.

Behaviour:
- Reset values: state IDLE; ap_done=0, ap_ready=0, ap_idle=1; stg_start=0; cur_stage=0; all stg_cycles=0; err=0.
- Reset asserted mid-sequence forces IDLE on the next edge. stg_start drops immediately and no ap_done is issued.

State machine:
- IDLE: ap_idle=1. If ap_start is sampled high at edge T, then at T+1: state START with stage 0, all counters cleared, err cleared.
- START(i): stg_start[i]=1 and counter i increments each cycle.
  - stg_ready[i] && !stg_done[i] -> WAIT(i).
  - stg_done[i] (with or without ready) -> advance; done implies ready.
- WAIT(i): stg_start[i]=0 and counter i increments. stg_done[i] -> advance.
- Advance:
  - If i < N_STAGES-1, next state is START(i+1) on the following cycle. No gap cycle is inserted.
  - If i = N_STAGES-1, next state is DONE.
- DONE: ap_done=ap_ready=1 for exactly one cycle, then IDLE.
  - If ap_start is still high in IDLE, a new run begins; this is legal back-to-back operation.

Latency and counters:
- Minimum sequence latency is 1 + sum(stage cycles) + 1 cycles, start-accept to ap_done.
- Counter i counts every cycle spent in START(i) or WAIT(i), including the done cycle. It saturates at 2^CNT_W-1 and holds its value after the run until the next accepted start.
- Stage runtime = 1 + cycles to ready (START) + cycles from ready to done (WAIT).

Handshake rules and boundary cases:
- stg_done/stg_ready of non-active stages and any strobe seen in IDLE/DONE are ignored.
- ap_start deasserted while busy has no effect; the sequence runs to completion.
- stg_start never overlaps between stages; at most one bit is high at any time.

Optional Feature:
- Macro: HEPT_SEQ_WDOG_EN.
- With the macro defined:
  - A per-stage watchdog counts cycles in START(i)/WAIT(i).
  - On reaching WDOG_CYCLES without stg_done[i], the block drops stg_start, goes to DONE, and pulses ap_done/ap_ready.
  - err is set on the same cycle as that ap_done pulse. It stays sticky until the next accepted start or reset.
  - cur_stage holds the failing index until the next start.
- Without the macro: no watchdog, no err port, and a stage may run indefinitely.

Decomposition:
- Package hept_seq_pkg holds:
  - state enum seq_state_t {IDLE, START, WAIT, DONE};
  - localparam CNT_SAT;
  - a function stage_slot(i) returning the bit offset into stg_cycles.
- One sub-module, hept_sat_counter (clear, enable, saturating CNT_W counter), instantiated N_STAGES times.
- The optional watchdog reuses one extra instance of hept_sat_counter.

Test Plan:
- Nominal: stage latencies ready at +2/done at +5, +1/+3, +4/+4. Required: stg_start one-hot in order 0,1,2; stg_cycles = {5,3,4}; ap_done pulses once, 1+12+1=14 cycles after start-accept.
- ready and done same cycle on the first START cycle for all stages: stg_cycles = {1,1,1}; no WAIT visits; ap_done 5 cycles after accept.
- Spurious stg_done[2] during stage 0, and stg_done[0] pulsed in IDLE: both ignored; sequence and counts unchanged.
- Reset pulsed while in WAIT(1): next cycle IDLE, stg_start=0, counters=0, no ap_done. A fresh ap_start then runs normally.
- Back-to-back: ap_start held through ap_done. Required: a second run starts 1 cycle after IDLE, and counters clear at the second accept.
- HEPT_SEQ_WDOG_EN, WDOG_CYCLES=10, stage 1 never done: ap_done with err=1 at cycle 10 of stage 1; cur_stage=1; stg_cycles[1]=10. The next start clears err.

Source files
------------

// File: rtl/hept_seq_pkg.sv
// Shared types and helpers for the HEPT stage sequencer.
package hept_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int SEQ_CNT_W = 16;
    localparam logic [SEQ_CNT_W-1:0] CNT_SAT = {SEQ_CNT_W{1'b1}};

    // Bit offset of stage i's counter inside the flattened stg_cycles bus.
    function automatic int stage_slot(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/hept_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module hept_sat_counter
    import hept_seq_pkg::*;
#(
    parameter int W = SEQ_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] SAT_V = (W == SEQ_CNT_W) ? W'(CNT_SAT) : {W{1'b1}};

    logic [W-1:0] count_r;

    // Count register: holds at the all-ones ceiling.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != SAT_V)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hept_stage_sequencer.sv
// Runs the HEPT ap_ctrl_hs stages in order from one top-level handshake and
// records per-stage cycle counts. Optional per-stage watchdog: HEPT_SEQ_WDOG_EN.
module hept_stage_sequencer
    import hept_seq_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic [N_STAGES-1:0]       stg_start,
    input  logic [N_STAGES-1:0]       stg_ready,
    input  logic [N_STAGES-1:0]       stg_done,
`ifdef HEPT_SEQ_WDOG_EN
    output logic                      err,
`endif
    output logic [$clog2(N_STAGES)-1:0] cur_stage,
    output logic [N_STAGES*CNT_W-1:0] stg_cycles
);

    localparam int SW = $clog2(N_STAGES);
    localparam logic [N_STAGES-1:0] STG_ONE = N_STAGES'(1);

    seq_state_t    state_r, state_s, adv_state_s;
    logic [SW-1:0] stage_r, stage_s, adv_stage_s, cur_stage_s, cur_stage_r;
    logic [N_STAGES-1:0] stg_start_r;
    logic          ap_done_r, ap_idle_r;
    logic          accept_s, in_stage_s, last_s, timeout_s;

    assign in_stage_s  = (state_r == START) || (state_r == WAIT);
    assign last_s      = (stage_r == SW'(N_STAGES-1));
    assign adv_state_s = last_s ? DONE : START;
    assign adv_stage_s = last_s ? stage_r : stage_r + SW'(1);

`ifdef HEPT_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_s;
    logic              advance_s, err_s, err_r;

    assign advance_s = in_stage_s && stg_done[stage_r];
    // Timeout fires on the last allowed stage cycle, so the stage counter ends at WDOG_CYCLES.
    assign timeout_s = in_stage_s && !stg_done[stage_r] &&
                       (wdog_cnt_s == WDOG_W'(WDOG_CYCLES - 1));
    assign err_s     = accept_s ? 1'b0 : (timeout_s ? 1'b1 : err_r);

    hept_sat_counter #(.W(WDOG_W)) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept_s || advance_s),
        .enable (in_stage_s),
        .count  (wdog_cnt_s)
    );

    // Sticky abort flag, cleared only by the next accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign err         = err_r;
    assign cur_stage_s = ((state_s == IDLE) && !err_s) ? '0 : stage_s;
`else
    assign timeout_s   = 1'b0;
    assign cur_stage_s = (state_s == IDLE) ? '0 : stage_s;
`endif

    // Next-state logic; done on the active stage takes priority over ready and timeout.
    always_comb begin
        state_s  = state_r;
        stage_s  = stage_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_s  = START;
                    stage_s  = '0;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                if (stg_done[stage_r]) begin
                    state_s = adv_state_s;
                    stage_s = adv_stage_s;
                end else if (timeout_s) begin
                    state_s = DONE;
                end else if (stg_ready[stage_r]) begin
                    state_s = WAIT;
                end else begin
                    state_s = START;
                end
            end
            WAIT: begin
                if (stg_done[stage_r]) begin
                    state_s = adv_state_s;
                    stage_s = adv_stage_s;
                end else if (timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and outputs registered from next-state values so they align with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            stage_r     <= '0;
            stg_start_r <= '0;
            ap_done_r   <= 1'b0;
            ap_idle_r   <= 1'b1;
            cur_stage_r <= '0;
        end else begin
            state_r     <= state_s;
            stage_r     <= stage_s;
            stg_start_r <= (state_s == START) ? (STG_ONE << stage_s) : '0;
            ap_done_r   <= (state_s == DONE);
            ap_idle_r   <= (state_s == IDLE);
            cur_stage_r <= cur_stage_s;
        end
    end

    assign stg_start = stg_start_r;
    assign ap_done   = ap_done_r;
    assign ap_ready  = ap_done_r;
    assign ap_idle   = ap_idle_r;
    assign cur_stage = cur_stage_r;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_cnt
        hept_sat_counter #(.W(CNT_W)) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .clear  (accept_s),
            .enable (in_stage_s && (stage_r == SW'(i))),
            .count  (stg_cycles[stage_slot(i, CNT_W) +: CNT_W])
        );
    end

endmodule

// File: tb/tb_hept_stage_sequencer.sv
// Self-checking bench for hept_stage_sequencer (define HEPT_SEQ_WDOG_EN for the watchdog build).
module tb_hept_stage_sequencer;

    localparam int N   = 3;
    localparam int CW  = 6;
    localparam int SAT = 63;

    typedef struct packed {
        logic [7:0] r0, r1, r2;
        logic [7:0] d0, d1, d2;
        logic [7:0] e0, e1, e2;
        logic [7:0] lat;
        logic       spur;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset, ap_start;
    logic          ap_done, ap_ready, ap_idle;
    logic [N-1:0]  stg_start, stg_ready, stg_done;
    logic [1:0]    cur_stage;
    logic [N*CW-1:0] stg_cycles;
`ifdef HEPT_SEQ_WDOG_EN
    logic          err;
`endif

    always #5 clock = ~clock;

    hept_stage_sequencer #(.N_STAGES(N), .CNT_W(CW), .WDOG_CYCLES(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_ready   (ap_ready),
        .ap_idle    (ap_idle),
        .stg_start  (stg_start),
        .stg_ready  (stg_ready),
        .stg_done   (stg_done),
`ifdef HEPT_SEQ_WDOG_EN
        .err        (err),
`endif
        .cur_stage  (cur_stage),
        .stg_cycles (stg_cycles)
    );

    int checks = 0, errors = 0;
    int cr[N], cd[N];
    int act, k, order, nstarts, done_cnt, onehot_bad, rdy_bad, cur_bad;
    bit spur_en, hold_ok;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    function automatic logic [31:0] cyc(input int i);
        return 32'(stg_cycles[i*CW +: CW]);
    endfunction

    function automatic vec_t mk(input int r0, r1, r2, d0, d1, d2, input bit spur);
        vec_t v;
        int   s;
        v.r0 = 8'(r0); v.r1 = 8'(r1); v.r2 = 8'(r2);
        v.d0 = 8'(d0); v.d1 = 8'(d1); v.d2 = 8'(d2);
        v.e0 = 8'((d0 > SAT) ? SAT : d0);
        v.e1 = 8'((d1 > SAT) ? SAT : d1);
        v.e2 = 8'((d2 > SAT) ? SAT : d2);
        s = d0 + d1 + d2;
        v.lat = 8'(s + 1);
        v.spur = spur;
        return v;
    endfunction

    // One cycle: sample at negedge, then drive the stage models for the coming edge.
    task automatic step();
        bit fin;
        @(negedge clock);
        if ($countones(stg_start) > 1) onehot_bad++;
        if (ap_ready !== ap_done) rdy_bad++;
        if (ap_done === 1'b1) done_cnt++;
        if (act < 0) begin
            for (int j = 0; j < N; j++) begin
                if (stg_start[j] === 1'b1 && act < 0) begin
                    act = j; k = 1; order = order * 4 + j; nstarts++;
                end
            end
        end else begin
            k++;
        end
        if (act >= 0 && cur_stage !== 2'(act)) cur_bad++;
        if (ap_idle === 1'b1 && !hold_ok && cur_stage !== 2'd0) cur_bad++;
        stg_ready = '0;
        stg_done  = '0;
        fin = 1'b0;
        if (act >= 0) begin
            if (k == cr[act]) stg_ready[act] = 1'b1;
            if (k == cd[act]) begin
                stg_ready[act] = 1'b1;
                stg_done[act]  = 1'b1;
                fin = 1'b1;
            end
            if (spur_en && act == 0 && k == 1) stg_done[2] = 1'b1;
        end
        if (fin) act = -1;
    endtask

    task automatic clear_stats();
        act = -1; order = 0; nstarts = 0; done_cnt = 0;
        onehot_bad = 0; rdy_bad = 0; cur_bad = 0;
    endtask

    task automatic wait_done(input int m0, input bit drop, output int lat);
        int m;
        m = m0;
        lat = -1;
        while (lat < 0 && m < 500) begin
            step();
            m++;
            if (ap_done === 1'b1) begin
                lat = m;
                if (drop) ap_start = 1'b0;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no ap_done within %0d cycles", m);
            ap_start = 1'b0;
        end
    endtask

    task automatic run(input vec_t v, input bit b2b);
        int lat, exp_ord, runs;
        cr[0] = int'(v.r0); cr[1] = int'(v.r1); cr[2] = int'(v.r2);
        cd[0] = int'(v.d0); cd[1] = int'(v.d1); cd[2] = int'(v.d2);
        clear_stats();
        spur_en = v.spur;
        if (v.spur) begin
            stg_done = 3'b001;
            step();
            chk("idle_spur_idle", 32'(ap_idle), 32'd1);
            chk("idle_spur_start", 32'(stg_start), 32'd0);
        end
        ap_start = 1'b1;
        hold_ok  = 1'b0;
        wait_done(0, !b2b, lat);
        chk("latency", lat, 32'(v.lat));
        runs = 1;
        if (b2b) begin
            step();
            chk("b2b_idle", 32'(ap_idle), 32'd1);
            step();
            chk("b2b_restart", 32'(stg_start), 32'd1);
            chk("b2b_clear", 32'(stg_cycles), 32'd0);
            ap_start = 1'b0;
            wait_done(1, 1'b1, lat);
            chk("b2b_latency", lat, 32'(v.lat));
            runs = 2;
        end
        step();
        step();
        chk("cycles0", cyc(0), 32'(v.e0));
        chk("cycles1", cyc(1), 32'(v.e1));
        chk("cycles2", cyc(2), 32'(v.e2));
        chk("done_pulses", 32'(done_cnt), 32'(runs));
        chk("idle_after", 32'(ap_idle), 32'd1);
        chk("onehot", 32'(onehot_bad), 32'd0);
        chk("ready_eq_done", 32'(rdy_bad), 32'd0);
        chk("cur_stage", 32'(cur_bad), 32'd0);
        exp_ord = 0;
        for (int r = 0; r < runs; r++)
            for (int j = 0; j < N; j++) exp_ord = exp_ord * 4 + j;
        chk("stage_count", 32'(nstarts), 32'(N * runs));
        chk("stage_order", 32'(order), 32'(exp_ord));
`ifdef HEPT_SEQ_WDOG_EN
        chk("err_clear", 32'(err), 32'd0);
`endif
        spur_en = 1'b0;
    endtask

    initial begin
        int m, lat;
        reset = 1'b1; ap_start = 1'b0; stg_ready = '0; stg_done = '0;
        spur_en = 1'b0; hold_ok = 1'b0;
        clear_stats();
        cr = '{1, 1, 1}; cd = '{1, 1, 1};

        tbl.push_back(mk(2, 1, 4, 5, 3, 4, 1'b0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1'b0));
        tbl.push_back(mk(2, 1, 4, 5, 3, 4, 1'b1));
        tbl.push_back(mk(1, 3, 2, 4, 3, 6, 1'b0));
`ifndef HEPT_SEQ_WDOG_EN
        tbl.push_back(mk(3, 1, 1, 70, 1, 2, 1'b0));
`endif

        step();
        step();
        chk("rst_idle", 32'(ap_idle), 32'd1);
        chk("rst_done", 32'(ap_done), 32'd0);
        chk("rst_ready", 32'(ap_ready), 32'd0);
        chk("rst_start", 32'(stg_start), 32'd0);
        chk("rst_cur", 32'(cur_stage), 32'd0);
        chk("rst_cycles", 32'(stg_cycles), 32'd0);
`ifdef HEPT_SEQ_WDOG_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        reset = 1'b0;
        step();

        foreach (tbl[i]) run(tbl[i], 1'b0);

        for (int n = 0; n < 20; n++) begin
            int rr[N], dd[N];
            for (int j = 0; j < N; j++) begin
                rr[j] = int'($urandom_range(1, 5));
                dd[j] = rr[j] + int'($urandom_range(0, 4));
            end
            run(mk(rr[0], rr[1], rr[2], dd[0], dd[1], dd[2], 1'($urandom_range(0, 1))), 1'b0);
        end

        run(tbl[0], 1'b1);

        // Reset pulsed while stage 1 is waiting for done.
        cr = '{1, 2, 1}; cd = '{2, 5, 2};
        clear_stats();
        ap_start = 1'b1;
        m = 0;
        while (!(act == 1 && k == cr[1] + 1) && m < 100) begin
            step();
            m++;
        end
        if (m >= 100) begin
            checks++;
            errors++;
            $display("FAIL rst_reach_wait: stage 1 wait not reached, cycles %0d", m);
        end
        ap_start = 1'b0;
        reset = 1'b1;
        act = -1;
        step();
        reset = 1'b0;
        chk("midrst_start", 32'(stg_start), 32'd0);
        chk("midrst_cycles", 32'(stg_cycles), 32'd0);
        chk("midrst_idle", 32'(ap_idle), 32'd1);
        chk("midrst_done", 32'(ap_done), 32'd0);
        chk("midrst_cur", 32'(cur_stage), 32'd0);
        done_cnt = 0;
        repeat (3) step();
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        run(tbl[0], 1'b0);

`ifdef HEPT_SEQ_WDOG_EN
        // Stage 1 never completes: abort after 10 stage cycles.
        cr = '{1, 2, 1}; cd = '{2, 1000, 1};
        clear_stats();
        ap_start = 1'b1;
        hold_ok = 1'b0;
        wait_done(0, 1'b1, lat);
        chk("wdog_latency", lat, 32'd13);
        chk("wdog_err", 32'(err), 32'd1);
        chk("wdog_cur_done", 32'(cur_stage), 32'd1);
        act = -1;
        hold_ok = 1'b1;
        step();
        chk("wdog_err_sticky", 32'(err), 32'd1);
        chk("wdog_cur_idle", 32'(cur_stage), 32'd1);
        chk("wdog_idle", 32'(ap_idle), 32'd1);
        chk("wdog_cycles0", cyc(0), 32'd2);
        chk("wdog_cycles1", cyc(1), 32'd10);
        chk("wdog_cycles2", cyc(2), 32'd0);
        run(tbl[0], 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
